// File: rtl/pe_core.sv
// Floating-point matrix-vector MAC array: per-lane FP32 multiply-accumulate of a latched weight column
// against a broadcast vector element. Rounding is toward zero, and denormals are flushed to zero.
module pe_core #(
  parameter int ARRAY_SIZE      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_DATA_WIDTH = 1024,
  parameter int K_ACCUM_DEPTH   = 64,
  parameter int OUTCOME_WIDTH   = 32
) (
  input  logic                                clk,
  input  logic                                srstn,
  input  logic                                alu_start,
  input  logic [8:0]                          cycle_num,
  input  logic [SRAM_DATA_WIDTH-1:0]          sram_rdata_w,
  input  logic [DATA_WIDTH-1:0]               sram_rdata_v,
  output logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome
);

  localparam logic [31:0] QNAN  = 32'h7fc0_0000;
  localparam logic [8:0]  K_LIM = 9'(K_ACCUM_DEPTH);

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] prod;
    logic [9:0]  e_sum;
    logic [9:0]  e_res;
    logic [22:0] frac;
    sgn   = a[31] ^ b[31];
    prod  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    frac  = prod[47] ? prod[46:24] : prod[45:23];
    // Biased exponent sum kept unsigned: overflow at >= 254+128, underflow at <= 127.
    e_sum = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, prod[47]};
    e_res = e_sum - 10'd127;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a)))
      fp_mul = QNAN;
    else if (is_inf(a) || is_inf(b))
      fp_mul = {sgn, 8'hff, 23'd0};
    else if (is_zero(a) || is_zero(b) || (e_sum <= 10'd127))
      fp_mul = '0;
    else if (e_sum >= 10'd382)
      fp_mul = {sgn, 8'hff, 23'd0};
    else
      fp_mul = {sgn, e_res[7:0], frac};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        a_big;
    logic        s_big;
    logic [31:0] big;
    logic [31:0] sml;
    logic [7:0]  d;
    logic [26:0] m_big;
    logic [26:0] m_sml;
    logic [26:0] m_sh;
    logic [26:0] diff;
    logic [26:0] norm;
    logic [27:0] sum;
    logic [8:0]  e_out;
    logic [4:0]  lz;
    logic        found;
    a_big = a[30:0] >= b[30:0];
    big   = a_big ? a : b;
    sml   = a_big ? b : a;
    s_big = big[31];
    d     = big[30:23] - sml[30:23];
    m_big = {1'b1, big[22:0], 3'b000};
    m_sml = {1'b1, sml[22:0], 3'b000};
    // Guard bits plus a sticky LSB keep truncation exact after alignment on both add and subtract.
    m_sh  = (d >= 8'd27) ? 27'd1
          : ((m_sml >> d) | {26'd0, |(m_sml & ((27'd1 << d) - 27'd1))});
    sum   = {1'b0, m_big} + {1'b0, m_sh};
    diff  = m_big - m_sh;
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!found && diff[26-i]) begin
        lz    = 5'(i);
        found = 1'b1;
      end
    end
    norm  = diff << lz;
    e_out = {1'b0, big[30:23]} + {8'd0, sum[27]};
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[31] != b[31])))
      fp_add = QNAN;
    else if (is_inf(a))
      fp_add = a;
    else if (is_inf(b))
      fp_add = b;
    else if (is_zero(a))
      fp_add = is_zero(b) ? '0 : b;
    else if (is_zero(b))
      fp_add = a;
    else if (a[31] == b[31]) begin
      if (e_out >= 9'd255)
        fp_add = {s_big, 8'hff, 23'd0};
      else
        fp_add = {s_big, e_out[7:0], sum[27] ? sum[26:4] : sum[25:3]};
    end
    else if ((diff == '0) || ({3'b000, lz} >= big[30:23]))
      fp_add = '0;
    else
      fp_add = {s_big, big[30:23] - {3'b000, lz}, norm[25:3]};
  endfunction

  logic [DATA_WIDTH-1:0]               weight_reg [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]               acc        [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]               w_in       [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]               prod       [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]               acc_next   [ARRAY_SIZE];
  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] acc_flat;
  logic                                first_step;
  logic                                step_en;

  assign first_step = (cycle_num == '0);
  assign step_en    = alu_start && (cycle_num < K_LIM);

  always_comb begin
    acc_flat = '0;
    for (int unsigned j = 0; j < ARRAY_SIZE; j++) begin
      w_in[j]     = sram_rdata_w[j*DATA_WIDTH +: DATA_WIDTH];
      // The first step multiplies the incoming column directly, since weight_reg is only loaded at this edge.
      prod[j]     = fp_mul(first_step ? w_in[j] : weight_reg[j], sram_rdata_v);
      acc_next[j] = first_step ? prod[j] : fp_add(acc[j], prod[j]);
      acc_flat[(ARRAY_SIZE-j)*OUTCOME_WIDTH-1 -: OUTCOME_WIDTH] = acc[j];
    end
  end

  always_ff @(posedge clk) begin
    if (srstn) begin
      for (int unsigned j = 0; j < ARRAY_SIZE; j++) begin
        weight_reg[j] <= '0;
        acc[j]        <= '0;
      end
      mul_outcome <= '0;
    end else begin
      if (step_en) begin
        for (int unsigned j = 0; j < ARRAY_SIZE; j++) begin
          if (first_step) weight_reg[j] <= w_in[j];
          acc[j] <= acc_next[j];
        end
      end
      mul_outcome <= acc_flat;
    end
  end

endmodule

// File: tb/tb_pe_core.sv
// Scoreboard bench for pe_core: the driver pushes the expected outcome from a real-arithmetic model,
// and the monitor pops and compares one outcome per clock.
module tb_pe_core;
  localparam int N = 32;
  localparam int W = 32;
  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  typedef logic [N*W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         srstn;
  logic         alu_start;
  logic [8:0]   cycle_num;
  logic [N*W-1:0] sram_rdata_w;
  logic [W-1:0] sram_rdata_v;
  logic [N*W-1:0] mul_outcome;

  always #5 clk = ~clk;

  pe_core #(
    .ARRAY_SIZE(N), .DATA_WIDTH(W), .SRAM_DATA_WIDTH(N*W), .K_ACCUM_DEPTH(64), .OUTCOME_WIDTH(W)
  ) dut (
    .clk(clk), .srstn(srstn), .alu_start(alu_start), .cycle_num(cycle_num),
    .sram_rdata_w(sram_rdata_w), .sram_rdata_v(sram_rdata_v), .mul_outcome(mul_outcome)
  );

  vec_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_w   [N];
  logic [31:0] m_acc [N];

  // Reference model: finite values go through double precision (exact for the stimulus ranges used)
  // and are then truncated to single; the special cases follow the stated IEEE exception rules.
  function automatic real f2r(input logic [31:0] a);
    if (a[30:23] == 8'h00) return 0.0;
    return $bitstoreal({a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real d);
    logic [63:0] b;
    int          e;
    if (d == 0.0) return 32'h0;
    b = $realtobits(d);
    e = int'(b[62:52]) - 896;
    if (e >= 255) return {b[63], 8'hff, 23'd0};
    if (e <= 0)   return 32'h0;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  function automatic logic m_zero(input logic [31:0] a);
    return a[30:23] == 8'h00;
  endfunction
  function automatic logic m_inf(input logic [31:0] a);
    return a[30:23] == 8'hff && a[22:0] == 23'd0;
  endfunction
  function automatic logic m_nan(input logic [31:0] a);
    return a[30:23] == 8'hff && a[22:0] != 23'd0;
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    if (m_nan(a) || m_nan(b)) return QNAN;
    if ((m_inf(a) && m_zero(b)) || (m_inf(b) && m_zero(a))) return QNAN;
    if (m_inf(a) || m_inf(b)) return {a[31] ^ b[31], 8'hff, 23'd0};
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    if (m_nan(a) || m_nan(b)) return QNAN;
    if (m_inf(a) && m_inf(b) && a[31] != b[31]) return QNAN;
    if (m_inf(a)) return a;
    if (m_inf(b)) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic vec_t pack_acc();
    vec_t r;
    for (int j = 0; j < N; j++) r[(N-j)*W-1 -: W] = m_acc[j];
    return r;
  endfunction

  function automatic vec_t splat(input logic [31:0] x);
    vec_t r;
    for (int j = 0; j < N; j++) r[j*W +: W] = x;
    return r;
  endfunction

  // Random operand in [2^-4, 2^5) with random sign; keeps all model sums exact in double.
  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'(123 + $urandom_range(0, 8)), 23'($urandom)};
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int j = 0; j < N; j++) r[j*W +: W] = rnd_f();
    return r;
  endfunction

  task automatic cyc(input logic rst, input logic st, input logic [8:0] cn,
                     input vec_t w, input logic [31:0] v);
    @(negedge clk);
    srstn = rst; alu_start = st; cycle_num = cn; sram_rdata_w = w; sram_rdata_v = v;
    if (rst) begin
      for (int j = 0; j < N; j++) begin m_w[j] = '0; m_acc[j] = '0; end
      // The output register clears at this same edge, so the pending expectation becomes zero too.
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
    end else if (st && cn == 9'd0) begin
      for (int j = 0; j < N; j++) begin
        m_w[j]   = w[j*W +: W];
        m_acc[j] = m_mul(m_w[j], v);
      end
    end else if (st && cn < 9'd64) begin
      for (int j = 0; j < N; j++) m_acc[j] = m_add(m_acc[j], m_mul(m_w[j], v));
    end
    exp_q.push_back(pack_acc());
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        n_vec++;
        if (mul_outcome !== e) begin
          n_bad++;
          for (int j = 0; j < N; j++) begin
            if (mul_outcome[(N-j)*W-1 -: W] !== e[(N-j)*W-1 -: W]) begin
              $display("FAIL scoreboard t=%0t lane %0d: got %h expected %h", $time, j,
                       mul_outcome[(N-j)*W-1 -: W], e[(N-j)*W-1 -: W]);
              break;
            end
          end
        end
      end
    end
  end

  task automatic chk_now(input string name, input int lane, input logic [31:0] exp_v);
    @(posedge clk);
    #2;
    n_vec++;
    if (mul_outcome[(N-lane)*W-1 -: W] !== exp_v) begin
      n_bad++;
      $display("FAIL %s lane %0d: got %h expected %h", name, lane,
               mul_outcome[(N-lane)*W-1 -: W], exp_v);
    end
  endtask

  task automatic chk(input string name, input int lane, input logic [31:0] exp_v);
    cyc(1'b0, 1'b0, 9'd1, rnd_vec(), rnd_f());
    chk_now(name, lane, exp_v);
  endtask

  initial begin : driver
    vec_t wpat;
    int   e_tab [16] = '{-8, -7, -6, -5, -4, -2, -1, 0, 0, 1, 1, 2, 2, 3, 3, 3};

    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'($urandom), 9'($urandom), rnd_vec(), rnd_f());
    cyc(1'b0, 1'b0, 9'd0, rnd_vec(), rnd_f());

    // Full run: power-of-two lane weights, v = 0.5*(i+1) for 64 steps, giving 1040*w per lane.
    for (int j = 0; j < N; j++) wpat[j*W +: W] = {1'b0, 8'(127 + e_tab[j % 16]), 23'd0};
    cyc(1'b0, 1'b1, 9'd0, wpat, 32'h0);
    for (int i = 0; i < 64; i++)
      cyc(1'b0, 1'b1, 9'(i), (i == 0) ? wpat : rnd_vec(), r2f(0.5 * real'(i + 1)));
    chk("full_run_lane0", 0, 32'h4082_0000);
    chk_now("full_run_lane7", 7, 32'h4482_0000);

    // Hold: alu_start low for 5 cycles with changing inputs, then resume.
    cyc(1'b0, 1'b1, 9'd0, rnd_vec(), rnd_f());
    for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1, 9'(i), rnd_vec(), rnd_f());
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 9'($urandom_range(0, 63)), rnd_vec(), rnd_f());
    for (int i = 4; i < 8; i++) cyc(1'b0, 1'b1, 9'(i), rnd_vec(), rnd_f());

    cyc(1'b0, 1'b1, 9'd0, splat(32'h4000_0000), 32'h4040_0000);
    cyc(1'b0, 1'b1, 9'd0, splat(32'h4000_0000), 32'h3f80_0000);
    chk("overwrite", 5, 32'h4000_0000);

    cyc(1'b0, 1'b1, 9'd0, splat(32'hc000_0000), 32'h3fc0_0000);
    cyc(1'b0, 1'b1, 9'd1, rnd_vec(), 32'hbfc0_0000);
    chk("cancel_to_pos_zero", 3, 32'h0000_0000);
    cyc(1'b0, 1'b1, 9'd0, splat(32'hc000_0000), 32'h3fc0_0000);
    chk("neg_product", 31, 32'hc040_0000);

    cyc(1'b0, 1'b1, 9'd64, rnd_vec(), rnd_f());
    cyc(1'b0, 1'b1, 9'd300, rnd_vec(), rnd_f());
    chk("limit_hold", 12, 32'hc040_0000);
    cyc(1'b0, 1'b1, 9'd1, rnd_vec(), 32'h3fc0_0000);
    chk_now("latency_old", 12, 32'hc040_0000);
    chk("latency_new", 12, 32'hc0c0_0000);

    cyc(1'b0, 1'b1, 9'd0, splat(32'h7f00_0000), 32'h4080_0000);
    chk("overflow_inf", 0, 32'h7f80_0000);
    cyc(1'b0, 1'b1, 9'd0, splat(32'h7f80_0000), 32'h0000_0000);
    chk("inf_times_zero", 1, QNAN);
    cyc(1'b0, 1'b1, 9'd0, splat(32'h0d80_0000), 32'h0d80_0000);
    chk("underflow_flush", 2, 32'h0000_0000);
    cyc(1'b0, 1'b1, 9'd0, splat(32'h0000_0001), 32'h3f80_0000);
    chk("denormal_zero", 4, 32'h0000_0000);

    // Randomized runs with holds, out-of-range steps and one reset mid-accumulation.
    for (int r = 0; r < 6; r++) begin
      int cn;
      int len;
      cn  = 0;
      len = $urandom_range(20, 60);
      cyc(1'b0, 1'b1, 9'd0, rnd_vec(), rnd_f());
      for (int s = 1; s < len; s++) begin
        int unsigned dice;
        dice = $urandom_range(0, 15);
        if (r == 3 && s == len / 2)
          cyc(1'b1, 1'b1, 9'(cn), rnd_vec(), rnd_f());
        else if (dice < 2)
          cyc(1'b0, 1'b0, 9'(cn + 1), rnd_vec(), rnd_f());
        else if (dice == 2)
          cyc(1'b0, 1'b1, 9'(64 + $urandom_range(0, 447)), rnd_vec(), rnd_f());
        else begin
          cn++;
          cyc(1'b0, 1'b1, 9'(cn), rnd_vec(), rnd_f());
        end
      end
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 9'd0, rnd_vec(), rnd_f());
    @(posedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
